// File: rtl/uart_instr_loader_pkg.sv
// Shared types and constants for the UART instruction loader.
// Holds the loader FSM encoding, the byte-phase enum and the instruction word geometry.
package uart_instr_loader_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    DONE   = 3'd2,
    RUN    = 3'd3,
    HALTED = 3'd4
  } state_e;

  typedef enum logic {
    PH_HI = 1'b0,
    PH_LO = 1'b1
  } phase_e;

  localparam logic [7:0] START_ADDR = 8'd1;
  localparam int         INSTR_W    = 16;

endpackage

// File: rtl/uart_instr_loader_idle_timer.sv
// Loadable up-counter with synchronous clear, count enable and a terminal-count pulse.
// tc is high while enabled and the count sits at term_val, so the owner acts on that cycle.
module loader_idle_timer #(
  parameter int W = 20
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic [W-1:0] term_val,
  output logic [W-1:0] count,
  output logic         tc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  assign tc = en && !clr && (count == term_val);

endmodule

// File: rtl/uart_instr_loader.sv
// Program loader: packs UART bytes into 16-bit words, writes them to instruction memory and gates the CPU.
// Optional build macro LOADER_CHECKSUM_EN adds load_checksum and load_word_count outputs.
module uart_instr_loader #(
  parameter int                 ADDR_W       = 8,
  parameter logic [19:0]        IDLE_TIMEOUT = 20'hFFFFF,
  parameter logic [ADDR_W-1:0]  START_ADDR   = ADDR_W'(8'd1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              cpu_start,
  input  logic              cpu_halt,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [15:0]       mem_wr_data,
  output logic              instr_transmit_done,
  output logic [ADDR_W-1:0] max_addr_instr,
  output logic              cpu_run_en,
  output logic              load_overflow,
  output logic              load_odd_byte,
  output logic              st_ready,
  output logic              st_running,
  output logic              st_halted,
`ifdef LOADER_CHECKSUM_EN
  output logic [7:0]        load_checksum,
  output logic [ADDR_W-1:0] load_word_count,
`endif
  output logic [2:0]        dbg_state
);

  import uart_instr_loader_pkg::*;

  // Handshake: rx_valid is a single-cycle strobe qualifying rx_data, no back-pressure.
  // mem_wr_en is a single-cycle write strobe qualifying mem_wr_addr/mem_wr_data.

  state_e            state, state_nxt;
  phase_e            phase;
  logic [7:0]        hi_byte;
  logic              armed;
  logic              addr_full;
  logic              accept;
  logic              tmr_en;
  logic              tmr_tc;
  logic [19:0]       tmr_count;

  assign accept = rx_valid && ((state == IDLE) || (state == LOAD));
  assign tmr_en = (state == LOAD) && armed && !rx_valid;

  loader_idle_timer #(.W(20)) u_idle_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (accept),
    .en       (tmr_en),
    .load     (1'b0),
    .load_val (20'd0),
    .term_val (IDLE_TIMEOUT - 20'd1),
    .count    (tmr_count),
    .tc       (tmr_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (rx_valid) state_nxt = LOAD;
      LOAD:    if (tmr_tc) state_nxt = DONE;
      DONE:    if (cpu_start) state_nxt = RUN;
      // Halt takes priority over a simultaneous pause request.
      RUN: begin
        if (cpu_halt) state_nxt = HALTED;
        else if (!cpu_start) state_nxt = DONE;
      end
      HALTED:  state_nxt = HALTED;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase          <= PH_HI;
      hi_byte        <= '0;
      armed          <= 1'b0;
      addr_full      <= 1'b0;
      mem_wr_en      <= 1'b0;
      mem_wr_addr    <= START_ADDR;
      mem_wr_data    <= '0;
      max_addr_instr <= '0;
      load_overflow  <= 1'b0;
      load_odd_byte  <= 1'b0;
    end else begin
      mem_wr_en <= 1'b0;
      if (mem_wr_en) begin
        armed <= 1'b1;
        // The top address is flagged at write time so it is kept rather than wrapped.
        if (!addr_full) mem_wr_addr <= mem_wr_addr + 1'b1;
      end
      if (accept) begin
        if (phase == PH_HI) begin
          hi_byte <= rx_data;
          phase   <= PH_LO;
        end else begin
          phase <= PH_HI;
          if (addr_full) begin
            load_overflow <= 1'b1;
          end else begin
            mem_wr_en      <= 1'b1;
            mem_wr_data    <= {hi_byte, rx_data};
            max_addr_instr <= mem_wr_addr;
            if (&mem_wr_addr) addr_full <= 1'b1;
          end
        end
      end else if (tmr_tc && (phase == PH_LO)) begin
        load_odd_byte <= 1'b1;
        phase         <= PH_HI;
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_checksum   <= '0;
      load_word_count <= '0;
    end else begin
      if (accept) load_checksum <= load_checksum + rx_data;
      if (mem_wr_en) load_word_count <= load_word_count + 1'b1;
    end
  end
`endif

  assign instr_transmit_done = (state == DONE) || (state == RUN) || (state == HALTED);
  assign cpu_run_en          = (state == RUN);
  assign st_ready            = (state == DONE);
  assign st_running          = (state == RUN);
  assign st_halted           = (state == HALTED);
  assign dbg_state           = state;

endmodule
